// File: rtl/rfphoenix_load_align_pkg.sv
// Shared widths and the stage-1 record of the load-align pipeline.
package rfphoenix_pkg;

  localparam int BUSWID     = 128;
  localparam int LINEWID    = 512;
  localparam int TAGWID     = 8;
  localparam int SELWID     = BUSWID / 8;
  localparam int LINE_LANES = LINEWID / BUSWID;
  localparam int ADRWID     = $clog2(LINE_LANES);
  localparam int LOWID      = $clog2(SELWID);
  localparam int NWID       = $clog2(SELWID) + 1;

  typedef struct packed {
    logic [BUSWID-1:0] lane;
    logic [LOWID-1:0]  lo;
    logic [NWID-1:0]   n;
    logic              err;
    logic              sgn;
    logic [TAGWID-1:0] tag;
  } ldalign_s1_t;

endpackage

// File: rtl/rfphoenix_load_align_sel_decode.sv
// Byte-enable decoder: lowest enabled byte, enabled byte count, and a flag for
// empty or non-contiguous enables. Shared with the store-side checker.
module rfphoenix_sel_decode
  import rfphoenix_pkg::*;
(
  input  logic [SELWID-1:0] sel,
  output logic [LOWID-1:0]  lo,
  output logic [NWID-1:0]   n,
  output logic              err
);

  logic [SELWID-1:0] run;

  always_comb begin
    lo = '0;
    n  = '0;
    for (int i = SELWID - 1; i >= 0; i--) begin
      if (sel[i]) lo = LOWID'(i);
    end
    for (int i = 0; i < SELWID; i++) begin
      n = n + NWID'(sel[i]);
    end
    // Contiguous enables become a 2^k-1 run once shifted down to bit 0.
    run = sel >> lo;
    err = (sel == '0) | ((run & (run + SELWID'(1))) != '0);
  end

endmodule

// File: rtl/rfphoenix_load_align.sv
// Load aligner: picks a lane from a cache line, right-justifies the enabled bytes
// and zero/sign-extends them, through a two-stage valid/ready pipeline.
module rfphoenix_load_align
  import rfphoenix_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [LINEWID-1:0] line_i,
  input  logic [ADRWID-1:0]  adr_i,
  input  logic [SELWID-1:0]  sel_i,
  input  logic               signed_i,
  input  logic [TAGWID-1:0]  tag_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [BUSWID-1:0]  resp_data_o,
  output logic [TAGWID-1:0]  resp_tag_o,
  output logic               resp_err_o
);

  logic [LINE_LANES-1:0][BUSWID-1:0] line_lanes;
  ldalign_s1_t       s1_d, s1_q;
  logic              s1_v, s2_v;
  logic              s2_adv;
  logic [LOWID-1:0]  dec_lo;
  logic [NWID-1:0]   dec_n;
  logic              dec_err;
  logic [BUSWID-1:0] shifted, aligned;
  logic              fill;

  rfphoenix_sel_decode u_sel_decode (
    .sel (sel_i),
    .lo  (dec_lo),
    .n   (dec_n),
    .err (dec_err)
  );

  assign line_lanes = line_i;

  always_comb begin
    s1_d.lane = line_lanes[adr_i];
    s1_d.lo   = dec_lo;
    s1_d.n    = dec_n;
    s1_d.err  = dec_err;
    s1_d.sgn  = signed_i;
    s1_d.tag  = tag_i;
  end

  assign s2_adv       = ~s2_v | resp_ready_i;
  assign req_ready_o  = ~s1_v | s2_adv;
  assign resp_valid_o = s2_v;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (req_ready_o) begin
      s1_v <= req_valid_i;
      if (req_valid_i) s1_q <= s1_d;
    end
  end

  // Bytes at or above n take the fill value; a full lane therefore passes through.
  always_comb begin
    shifted = s1_q.lane >> {s1_q.lo, 3'b000};
    fill    = 1'b0;
    for (int b = 0; b < SELWID; b++) begin
      if (NWID'(b + 1) == s1_q.n) fill = s1_q.sgn & shifted[b*8+7];
    end
    aligned = '0;
    for (int b = 0; b < SELWID; b++) begin
      aligned[b*8 +: 8] = (NWID'(b) < s1_q.n) ? shifted[b*8 +: 8] : {8{fill}};
    end
    if (s1_q.err) aligned = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_v        <= 1'b0;
      resp_data_o <= '0;
      resp_tag_o  <= '0;
      resp_err_o  <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        resp_data_o <= aligned;
        resp_tag_o  <= s1_q.tag;
        resp_err_o  <= s1_q.err;
      end
    end
  end

endmodule
